mips_mc_control: RTL and testbench

- Multicycle MIPS main controller. It is the initiator side of the ALU control interface: it drives the 4-bit ALU control code and the operand-select lines, and it consumes the ALU zero flag.
- It sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Datapath enables it drives: PC, IR, memory, register file.
- It sits between the instruction register and the datapath muxes, alongside the ALU.

---
 rtl/mips_pkg.sv | 82 ++++++++
 rtl/mips_mc_control_if.sv | 37 +++
 rtl/mips_alu_decoder.sv | 60 ++++++
 rtl/mips_mc_control.sv | 156 +++++++++++++++
 tb/tb_mips_mc_control.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, functs,
// ALU control codes, FSM state encodings and datapath mux encodings.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUC_W  = 4;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned SRCB_W  = 2;
  localparam int unsigned PCSRC_W = 2;

  // Opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // R-type functs (IR[5:0])
  localparam logic [FUNCT_W-1:0] F_SLL = 6'b000000;
  localparam logic [FUNCT_W-1:0] F_SRL = 6'b000010;
  localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_NOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

  // ALU control codes, shared with the ALU
  localparam logic [ALUC_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_SLL = 4'b1000;
  localparam logic [ALUC_W-1:0] ALU_NOR = 4'b1100;
  localparam logic [ALUC_W-1:0] ALU_SRL = 4'b1111;

  // ALU B operand select
  localparam logic [SRCB_W-1:0] SRCB_REG    = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  // Class of ALU operation requested by the FSM; the decoder resolves it
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_IMM   = 2'd3
  } alu_op_e;

  function automatic logic is_i_alu(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Controller <-> datapath/ALU interface.
// master: the controller (drives o_* enables/selects, consumes IR fields and zero flag)
// slave : the datapath side (drives IR fields and zero flag, consumes o_*)
interface mips_mc_control_if;
  import mips_pkg::*;

  logic [OP_W-1:0]    i_opcode;
  logic [FUNCT_W-1:0] i_funct;
  logic               i_zf;

  logic               o_pc_we;
  logic               o_iord;
  logic               o_mem_we;
  logic               o_ir_we;
  logic               o_reg_dst;
  logic               o_mem_to_reg;
  logic               o_reg_we;
  logic               o_alu_src_a;
  logic [SRCB_W-1:0]  o_alu_src_b;
  logic               o_zext;
  logic [PCSRC_W-1:0] o_pc_src;
  logic [ALUC_W-1:0]  o_alu_control;
  logic               o_illegal;
  logic [STATE_W-1:0] o_state;

  modport master (
    input  i_opcode, i_funct, i_zf,
    output o_pc_we, o_iord, o_mem_we, o_ir_we, o_reg_dst, o_mem_to_reg, o_reg_we,
           o_alu_src_a, o_alu_src_b, o_zext, o_pc_src, o_alu_control, o_illegal, o_state
  );

  modport slave (
    output i_opcode, i_funct, i_zf,
    input  o_pc_we, o_iord, o_mem_we, o_ir_we, o_reg_dst, o_mem_to_reg, o_reg_we,
           o_alu_src_a, o_alu_src_b, o_zext, o_pc_src, o_alu_control, o_illegal, o_state
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// ALU decoder: maps (ALU op class, funct, opcode) to the ALU control code and
// immediate extension mode. Also flags whether the funct is a supported R-type.
// Ports: alu_op_i (class), funct_i, opcode_i -> alu_control_o, zext_o, funct_ok_o
module mips_alu_decoder
  import mips_pkg::*;
(
  input  alu_op_e             alu_op_i,
  input  logic [FUNCT_W-1:0]  funct_i,
  input  logic [OP_W-1:0]     opcode_i,
  output logic [ALUC_W-1:0]   alu_control_o,
  output logic                zext_o,
  output logic                funct_ok_o
);

  logic [ALUC_W-1:0] r_ctrl;

  // R-type funct lookup
  always_comb begin
    r_ctrl     = ALU_ADD;
    funct_ok_o = 1'b1;
    case (funct_i)
      F_ADD:   r_ctrl = ALU_ADD;
      F_SUB:   r_ctrl = ALU_SUB;
      F_AND:   r_ctrl = ALU_AND;
      F_OR:    r_ctrl = ALU_OR;
      F_NOR:   r_ctrl = ALU_NOR;
      F_SLT:   r_ctrl = ALU_SLT;
      F_SLL:   r_ctrl = ALU_SLL;
      F_SRL:   r_ctrl = ALU_SRL;
      default: funct_ok_o = 1'b0;
    endcase
  end

  // Resolve the class; immediate ops pick their code and extension from the opcode
  always_comb begin
    alu_control_o = ALU_ADD;
    zext_o        = 1'b0;
    case (alu_op_i)
      ALUOP_ADD:   alu_control_o = ALU_ADD;
      ALUOP_SUB:   alu_control_o = ALU_SUB;
      ALUOP_FUNCT: alu_control_o = r_ctrl;
      ALUOP_IMM: begin
        case (opcode_i)
          OP_SLTI: alu_control_o = ALU_SLT;
          OP_ANDI: begin
            alu_control_o = ALU_AND;
            zext_o        = 1'b1;
          end
          OP_ORI: begin
            alu_control_o = ALU_OR;
            zext_o        = 1'b1;
          end
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main controller. Sequences FETCH/DECODE/execute/memory/
// writeback and drives datapath enables, mux selects and the ALU control code.
// Ports: i_clk, i_rst (async, active-high), bus (master modport: IR opcode/funct
// and ALU zero flag in; PC/IR/memory/register-file enables, selects, ALU code,
// illegal pulse and debug state out).
module mips_mc_control
  import mips_pkg::*;
#(
  parameter logic [STATE_W-1:0] RESET_STATE = 4'd0
) (
  input logic               i_clk,
  input logic               i_rst,
  mips_mc_control_if.master bus
);

  state_e state_q, state_d;

  logic               pc_we_c, iord_c, mem_we_c, ir_we_c;
  logic               reg_dst_c, mem_to_reg_c, reg_we_c, alu_src_a_c;
  logic [SRCB_W-1:0]  alu_src_b_c;
  logic [PCSRC_W-1:0] pc_src_c;
  logic               illegal_c;
  alu_op_e            alu_op_c;
  logic [ALUC_W-1:0]  alu_control_c;
  logic               zext_c;
  logic               funct_ok_c;

  mips_alu_decoder u_alu_dec (
    .alu_op_i      (alu_op_c),
    .funct_i       (bus.i_funct),
    .opcode_i      (bus.i_opcode),
    .alu_control_o (alu_control_c),
    .zext_o        (zext_c),
    .funct_ok_o    (funct_ok_c)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and Moore outputs from state plus the stable IR fields
  always_comb begin
    state_d     = S_FETCH;
    pc_we_c     = 1'b0;
    iord_c      = 1'b0;
    mem_we_c    = 1'b0;
    ir_we_c     = 1'b0;
    reg_dst_c   = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_we_c    = 1'b0;
    alu_src_a_c = 1'b0;
    alu_src_b_c = SRCB_REG;
    pc_src_c    = PCSRC_ALU;
    illegal_c   = 1'b0;
    alu_op_c    = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        ir_we_c     = 1'b1;
        pc_we_c     = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = SRCB_IMM_SH;
        if (bus.i_opcode == OP_LW || bus.i_opcode == OP_SW) begin
          state_d = S_MEMADR;
        end else if (bus.i_opcode == OP_RTYPE) begin
          if (funct_ok_c) begin
            state_d = S_EXEC_R;
          end else begin
            illegal_c = 1'b1;
          end
        end else if (bus.i_opcode == OP_BEQ || bus.i_opcode == OP_BNE) begin
          state_d = S_BRANCH;
        end else if (is_i_alu(bus.i_opcode)) begin
          state_d = S_EXEC_I;
        end else if (bus.i_opcode == OP_J) begin
          state_d = S_JUMP;
        end else begin
          illegal_c = 1'b1;
        end
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        state_d     = (bus.i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_c  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_we_c     = 1'b1;
      end
      S_MEMWR: begin
        iord_c   = 1'b1;
        mem_we_c = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst_c = 1'b1;
        reg_we_c  = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALUOP_IMM;
        state_d     = S_IWB;
      end
      S_IWB: begin
        reg_we_c = 1'b1;
        alu_op_c = ALUOP_IMM;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALUOP_SUB;
        pc_src_c    = PCSRC_ALUOUT;
        // Branch decision uses the zero flag of the compare in this same cycle
        pc_we_c     = (bus.i_opcode == OP_BEQ) ? bus.i_zf : ~bus.i_zf;
      end
      S_JUMP: begin
        pc_src_c = PCSRC_JUMP;
        pc_we_c  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are held low for as long as reset is asserted
  assign bus.o_pc_we       = pc_we_c & ~i_rst;
  assign bus.o_mem_we      = mem_we_c & ~i_rst;
  assign bus.o_ir_we       = ir_we_c & ~i_rst;
  assign bus.o_reg_we      = reg_we_c & ~i_rst;
  assign bus.o_illegal     = illegal_c & ~i_rst;
  assign bus.o_iord        = iord_c;
  assign bus.o_reg_dst     = reg_dst_c;
  assign bus.o_mem_to_reg  = mem_to_reg_c;
  assign bus.o_alu_src_a   = alu_src_a_c;
  assign bus.o_alu_src_b   = alu_src_b_c;
  assign bus.o_zext        = zext_c;
  assign bus.o_pc_src      = pc_src_c;
  assign bus.o_alu_control = alu_control_c;
  assign bus.o_state       = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: reset corner cases, a table of
// per-instruction summaries, and random instructions against a trace model.
module tb_mips_mc_control;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_mc_control_if bus();

  mips_mc_control #(.RESET_STATE(4'd0)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_we;
    logic       iord;
    logic       mem_we;
    logic       ir_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_we;
    logic       src_a;
    logic [1:0] src_b;
    logic       zext;
    logic [1:0] pc_src;
    logic [3:0] alu;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zf;
    int         len;
    logic [3:0] alu3;
    logic       zext3;
    logic       pcwe3;
    int         regw;
    int         memw;
    int         ill;
  } vec_t;

  out_t exp_q[$];
  vec_t vecs[$];

  function automatic out_t sample();
    out_t s;
    s.state      = bus.o_state;
    s.pc_we      = bus.o_pc_we;
    s.iord       = bus.o_iord;
    s.mem_we     = bus.o_mem_we;
    s.ir_we      = bus.o_ir_we;
    s.reg_dst    = bus.o_reg_dst;
    s.mem_to_reg = bus.o_mem_to_reg;
    s.reg_we     = bus.o_reg_we;
    s.src_a      = bus.o_alu_src_a;
    s.src_b      = bus.o_alu_src_b;
    s.zext       = bus.o_zext;
    s.pc_src     = bus.o_pc_src;
    s.alu        = bus.o_alu_control;
    s.illegal    = bus.o_illegal;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Quiet cycle: every signal zero except the default ADD code
  function automatic out_t idle(input logic [3:0] st);
    out_t o;
    o       = '0;
    o.state = st;
    o.alu   = 4'b0010;
    return o;
  endfunction

  // {supported, ALU code} for an R-type funct
  function automatic logic [4:0] r_code(input logic [5:0] f);
    case (f)
      6'b100000: return 5'b1_0010;
      6'b100010: return 5'b1_0110;
      6'b100100: return 5'b1_0000;
      6'b100101: return 5'b1_0001;
      6'b100111: return 5'b1_1100;
      6'b101010: return 5'b1_0111;
      6'b000000: return 5'b1_1000;
      6'b000010: return 5'b1_1111;
      default:   return 5'b0_0010;
    endcase
  endfunction

  // Expected per-cycle trace of one instruction, FETCH through its last cycle
  function automatic void build(input logic [5:0] op, input logic [5:0] funct, input logic zf);
    out_t o;
    out_t d;
    logic [4:0] rc;
    rc = r_code(funct);
    exp_q.delete();
    o = idle(4'd0); o.ir_we = 1'b1; o.pc_we = 1'b1; o.src_b = 2'b01;
    exp_q.push_back(o);
    d = idle(4'd1); d.src_b = 2'b11;
    case (op)
      6'b100011, 6'b101011: begin
        exp_q.push_back(d);
        o = idle(4'd2); o.src_a = 1'b1; o.src_b = 2'b10;
        exp_q.push_back(o);
        if (op == 6'b100011) begin
          o = idle(4'd3); o.iord = 1'b1;
          exp_q.push_back(o);
          o = idle(4'd4); o.mem_to_reg = 1'b1; o.reg_we = 1'b1;
          exp_q.push_back(o);
        end else begin
          o = idle(4'd5); o.iord = 1'b1; o.mem_we = 1'b1;
          exp_q.push_back(o);
        end
      end
      6'b000000: begin
        if (rc[4]) begin
          exp_q.push_back(d);
          o = idle(4'd6); o.src_a = 1'b1; o.alu = rc[3:0];
          exp_q.push_back(o);
          o = idle(4'd7); o.reg_dst = 1'b1; o.reg_we = 1'b1;
          exp_q.push_back(o);
        end else begin
          d.illegal = 1'b1;
          exp_q.push_back(d);
        end
      end
      6'b000100, 6'b000101: begin
        exp_q.push_back(d);
        o = idle(4'd10); o.src_a = 1'b1; o.alu = 4'b0110; o.pc_src = 2'b01;
        o.pc_we = (op == 6'b000100) ? zf : !zf;
        exp_q.push_back(o);
      end
      6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
        exp_q.push_back(d);
        o = idle(4'd8); o.src_a = 1'b1; o.src_b = 2'b10;
        if (op == 6'b001010) o.alu = 4'b0111;
        if (op == 6'b001100) begin o.alu = 4'b0000; o.zext = 1'b1; end
        if (op == 6'b001101) begin o.alu = 4'b0001; o.zext = 1'b1; end
        exp_q.push_back(o);
        o.state = 4'd9; o.src_a = 1'b0; o.src_b = 2'b00; o.reg_we = 1'b1;
        exp_q.push_back(o);
      end
      6'b000010: begin
        exp_q.push_back(d);
        o = idle(4'd11); o.pc_src = 2'b10; o.pc_we = 1'b1;
        exp_q.push_back(o);
      end
      default: begin
        d.illegal = 1'b1;
        exp_q.push_back(d);
      end
    endcase
  endfunction

  // Run one instruction from FETCH and compare every cycle against the model
  task automatic run_model(input logic [5:0] op, input logic [5:0] funct, input logic zf,
                           input string tag);
    out_t s;
    build(op, funct, zf);
    bus.i_opcode = op;
    bus.i_funct  = funct;
    bus.i_zf     = zf;
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      s = sample();
      check($sformatf("%s_op%0h_f%0h_z%0d_c%0d", tag, op, funct, zf, i),
            64'(s), 64'(exp_q[i]));
      tick();
    end
    check($sformatf("%s_op%0h_end_state", tag, op), 64'(bus.o_state), 64'(0));
  endtask

  // Run one table vector, summarising the instruction's effect
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0;
    int regw = 0;
    int memw = 0;
    int ill = 0;
    logic [5:0] key = '0;
    out_t s;
    bus.i_opcode = v.op;
    bus.i_funct  = v.funct;
    bus.i_zf     = v.zf;
    #1;
    for (int c = 0; c < 8; c++) begin
      s = sample();
      cyc++;
      regw += int'(s.reg_we);
      memw += int'(s.mem_we);
      ill  += int'(s.illegal);
      if (c == 2) key = {s.alu, s.zext, s.pc_we};
      tick();
      if (bus.o_state == 4'd0) break;
    end
    check($sformatf("vec%0d_len", idx), 64'(cyc), 64'(v.len));
    check($sformatf("vec%0d_reg_we_count", idx), 64'(regw), 64'(v.regw));
    check($sformatf("vec%0d_mem_we_count", idx), 64'(memw), 64'(v.memw));
    check($sformatf("vec%0d_illegal_count", idx), 64'(ill), 64'(v.ill));
    if (v.len >= 3)
      check($sformatf("vec%0d_exec_alu_zext_pcwe", idx), 64'(key),
            64'({v.alu3, v.zext3, v.pcwe3}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops [11];
    logic [5:0] fns [9];
    logic [5:0] op;
    logic [5:0] fn;
    logic [31:0] r;
    out_t s;

    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000,
            6'b001010, 6'b001100, 6'b001101, 6'b000010, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010,
            6'b000000, 6'b000010, 6'b001000};

    //        op         funct      zf  len alu3     z  pcwe regw memw ill
    vecs.push_back('{6'b100011, 6'b000000, 1'b0, 5, 4'b0010, 1'b0, 1'b0, 1, 0, 0});
    vecs.push_back('{6'b101011, 6'b000000, 1'b0, 4, 4'b0010, 1'b0, 1'b0, 0, 1, 0});
    vecs.push_back('{6'b000000, 6'b100111, 1'b0, 4, 4'b1100, 1'b0, 1'b0, 1, 0, 0});
    vecs.push_back('{6'b000000, 6'b000010, 1'b0, 4, 4'b1111, 1'b0, 1'b0, 1, 0, 0});
    vecs.push_back('{6'b000000, 6'b100010, 1'b1, 4, 4'b0110, 1'b0, 1'b0, 1, 0, 0});
    vecs.push_back('{6'b000000, 6'b000000, 1'b0, 4, 4'b1000, 1'b0, 1'b0, 1, 0, 0});
    vecs.push_back('{6'b000100, 6'b000000, 1'b1, 3, 4'b0110, 1'b0, 1'b1, 0, 0, 0});
    vecs.push_back('{6'b000100, 6'b000000, 1'b0, 3, 4'b0110, 1'b0, 1'b0, 0, 0, 0});
    vecs.push_back('{6'b000101, 6'b000000, 1'b1, 3, 4'b0110, 1'b0, 1'b0, 0, 0, 0});
    vecs.push_back('{6'b000101, 6'b000000, 1'b0, 3, 4'b0110, 1'b0, 1'b1, 0, 0, 0});
    vecs.push_back('{6'b001100, 6'b000000, 1'b0, 4, 4'b0000, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back('{6'b001010, 6'b000000, 1'b0, 4, 4'b0111, 1'b0, 1'b0, 1, 0, 0});
    vecs.push_back('{6'b001101, 6'b000000, 1'b0, 4, 4'b0001, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back('{6'b000010, 6'b000000, 1'b0, 3, 4'b0010, 1'b0, 1'b1, 0, 0, 0});
    vecs.push_back('{6'b111111, 6'b000000, 1'b0, 2, 4'b0010, 1'b0, 1'b0, 0, 0, 1});
    vecs.push_back('{6'b000000, 6'b001000, 1'b0, 2, 4'b0010, 1'b0, 1'b0, 0, 0, 1});

    bus.i_opcode = 6'b100011;
    bus.i_funct  = '0;
    bus.i_zf     = 1'b0;

    // Power-on reset: FETCH values, every enable low
    #12;
    s = sample();
    check("reset_enables", 64'({s.state, s.pc_we, s.mem_we, s.ir_we, s.reg_we, s.illegal}), 64'(0));
    check("reset_fetch_selects", 64'({s.alu, s.src_b, s.src_a, s.iord, s.pc_src}),
          64'({4'b0010, 2'b01, 1'b0, 1'b0, 2'b00}));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("release_fetch", 64'({bus.o_state, bus.o_ir_we, bus.o_pc_we}), 64'({4'd0, 1'b1, 1'b1}));

    // lw interrupted by reset in MEMRD
    bus.i_opcode = 6'b100011;
    tick(); tick(); tick();
    check("lw_reached_memrd", 64'(bus.o_state), 64'(3));
    rst = 1'b1;
    #1;
    s = sample();
    check("mid_reset_enables", 64'({s.state, s.pc_we, s.mem_we, s.ir_we, s.reg_we, s.illegal}), 64'(0));
    tick();
    s = sample();
    check("held_reset_enables", 64'({s.state, s.pc_we, s.mem_we, s.ir_we, s.reg_we, s.illegal}), 64'(0));
    rst = 1'b0;
    #1;
    check("post_release_fetch", 64'({bus.o_state, bus.o_ir_we, bus.o_pc_we}), 64'({4'd0, 1'b1, 1'b1}));
    run_model(6'b100011, 6'b000000, 1'b0, "after_reset");

    // Directed traces from the test plan
    run_model(6'b000000, 6'b100111, 1'b0, "dir");
    run_model(6'b000000, 6'b000010, 1'b0, "dir");
    run_model(6'b001100, 6'b000000, 1'b0, "dir");
    run_model(6'b001010, 6'b000000, 1'b0, "dir");
    run_model(6'b000100, 6'b000000, 1'b1, "dir");
    run_model(6'b000101, 6'b000000, 1'b1, "dir");
    run_model(6'b111111, 6'b000000, 1'b0, "dir");
    run_model(6'b000000, 6'b001000, 1'b0, "dir");

    // Table vectors
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Random instructions against the trace model
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 11);
      if (r == 11) begin
        r  = $urandom();
        op = r[5:0];
      end else begin
        op = ops[r];
      end
      r = $urandom_range(0, 9);
      if (r == 9) begin
        r  = $urandom();
        fn = r[5:0];
      end else begin
        fn = fns[r];
      end
      r = $urandom();
      run_model(op, fn, r[0], "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
